demux4_buf: RTL and testbench

Registered 1-to-4 stream demultiplexer: the write-side counterpart to the 4:1 `mux4` select path. It accepts one valid/ready input stream tagged with a 2-bit destination and delivers each word to exactly one of four output channels. Each channel has a single-entry holding register, so output data is always registered. It sits between an issuing stage and up to four independent consumers, for example writeback ports or functional-unit queues.

---
 rtl/demux4_buf_pkg.sv | 10 +
 rtl/demux4_slot.sv | 36 +++
 rtl/demux4_buf.sv | 57 +++++
 tb/tb_demux4_buf.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/demux4_buf_pkg.sv
// Shared types for the 1-to-4 stream demultiplexer.
package demux4_buf_pkg;

  // Number of output channels fed by the demultiplexer
  localparam int DEMUX_CHANNELS = 4;

  // Destination channel tag carried alongside each input word
  typedef logic [1:0] demux_sel_t;

endpackage

// File: rtl/demux4_slot.sv
// Single-entry holding register for one demux output channel.
// A load always wins over a drain, so a same-cycle drain and refill
// leaves the slot full with the new word and no bubble.
module demux4_slot #(
  parameter int width = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [width-1:0] d,
  input  logic             ready,
  output logic             valid,
  output logic [width-1:0] q
);

  // Occupancy flag: set by a load, cleared by a drain without a refill
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

  // Held word: only a load changes it, so it stays stable while stalled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/demux4_buf.sv
// Registered 1-to-4 stream demultiplexer. Each input word is steered by
// in_sel into one of four single-entry slots; backpressure depends only
// on the selected slot so a stalled consumer never blocks the others.
module demux4_buf
  import demux4_buf_pkg::*;
#(
  parameter int width = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  demux_sel_t                in_sel,
  input  logic [width-1:0]          in_data,
  output logic [DEMUX_CHANNELS-1:0] out_valid,
  input  logic [DEMUX_CHANNELS-1:0] out_ready,
  output logic [width-1:0]          out_data0,
  output logic [width-1:0]          out_data1,
  output logic [width-1:0]          out_data2,
  output logic [width-1:0]          out_data3
);

  logic [DEMUX_CHANNELS-1:0] load;
  logic [width-1:0]          slot_data [DEMUX_CHANNELS];

  // The selected slot can accept when empty or when it drains this cycle;
  // forced low in reset so nothing is accepted while slots are cleared
  assign in_ready = !rst && (!out_valid[in_sel] || out_ready[in_sel]);

  // Decode the accepted word into a one-hot load for its destination slot
  always_comb begin
    load = '0;
    if (in_valid && in_ready) begin
      load[in_sel] = 1'b1;
    end
  end

  for (genvar i = 0; i < DEMUX_CHANNELS; i++) begin : g_slot
    demux4_slot #(
      .width (width)
    ) u_slot (
      .clk   (clk),
      .rst   (rst),
      .load  (load[i]),
      .d     (in_data),
      .ready (out_ready[i]),
      .valid (out_valid[i]),
      .q     (slot_data[i])
    );
  end

  assign out_data0 = slot_data[0];
  assign out_data1 = slot_data[1];
  assign out_data2 = slot_data[2];
  assign out_data3 = slot_data[3];

endmodule

// File: tb/tb_demux4_buf.sv
// Directed and scoreboarded checks for demux4_buf.
module tb_demux4_buf;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_sel;
  logic [31:0] in_data;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready;
  logic [31:0] out_data0;
  logic [31:0] out_data1;
  logic [31:0] out_data2;
  logic [31:0] out_data3;

  int checkCount = 0;
  int passCount  = 0;

  logic [31:0] expQ [4][$];
  int pushCount = 0;
  int popCount  = 0;

  demux4_buf #(.width(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sel    (in_sel),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data0 (out_data0),
    .out_data1 (out_data1),
    .out_data2 (out_data2),
    .out_data3 (out_data3)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic v, input logic [1:0] sel,
                               input logic [31:0] data, input logic [3:0] ordy);
    in_valid  = v;
    in_sel    = sel;
    in_data   = data;
    out_ready = ordy;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
  endtask

  // Advance to just after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] dataOf(input int ch);
    case (ch)
      0:       return out_data0;
      1:       return out_data1;
      2:       return out_data2;
      default: return out_data3;
    endcase
  endfunction

  initial begin
    rst = 1'b1;
    applyStimulus(1'b1, 2'd0, 32'h0, 4'b0000);
    step();
    step();

    // Reset values
    checkOutput("reset_out_valid", {28'h0, out_valid}, 32'h0);
    checkOutput("reset_data0", out_data0, 32'h0);
    checkOutput("reset_data1", out_data1, 32'h0);
    checkOutput("reset_data2", out_data2, 32'h0);
    checkOutput("reset_data3", out_data3, 32'h0);
    checkOutput("reset_in_ready", {31'h0, in_ready}, 32'h0);

    rst = 1'b0;
    applyStimulus(1'b0, 2'd0, 32'h0, 4'b0000);
    #1;
    checkOutput("idle_in_ready", {31'h0, in_ready}, 32'h1);

    // Single word to channel 2, then a blocked second word, then refill
    applyStimulus(1'b1, 2'd2, 32'hDEADBEEF, 4'b0000);
    #1;
    checkOutput("single_in_ready", {31'h0, in_ready}, 32'h1);
    step();
    checkOutput("single_out_valid", {28'h0, out_valid}, 32'h4);
    checkOutput("single_data2", out_data2, 32'hDEADBEEF);
    applyStimulus(1'b1, 2'd2, 32'h12345678, 4'b0000);
    #1;
    checkOutput("full_in_ready", {31'h0, in_ready}, 32'h0);
    step();
    checkOutput("stall_data2", out_data2, 32'hDEADBEEF);
    checkOutput("stall_out_valid", {28'h0, out_valid}, 32'h4);
    applyStimulus(1'b1, 2'd2, 32'h12345678, 4'b0100);
    #1;
    checkOutput("refill_in_ready", {31'h0, in_ready}, 32'h1);
    step();
    checkOutput("refill_out_valid", {28'h0, out_valid}, 32'h4);
    checkOutput("refill_data2", out_data2, 32'h12345678);
    applyStimulus(1'b0, 2'd2, 32'h0, 4'b0100);
    step();
    checkOutput("drain_out_valid", {28'h0, out_valid}, 32'h0);

    // Streaming words 1..8 into channel 0 at one per cycle
    for (int i = 1; i <= 8; i++) begin
      applyStimulus(1'b1, 2'd0, 32'(i), 4'b0001);
      #1;
      checkOutput($sformatf("stream_in_ready_%0d", i), {31'h0, in_ready}, 32'h1);
      step();
      checkOutput($sformatf("stream_valid_%0d", i), {28'h0, out_valid}, 32'h1);
      checkOutput($sformatf("stream_data_%0d", i), out_data0, 32'(i));
    end
    applyStimulus(1'b0, 2'd0, 32'h0, 4'b0001);
    step();
    checkOutput("stream_end_valid", {28'h0, out_valid}, 32'h0);

    // Isolation: stalled channel 1 does not block channels 0 and 3
    applyStimulus(1'b1, 2'd1, 32'h11, 4'b0000);
    step();
    applyStimulus(1'b1, 2'd0, 32'hA0, 4'b0000);
    #1;
    checkOutput("iso_ready_ch0", {31'h0, in_ready}, 32'h1);
    step();
    applyStimulus(1'b1, 2'd3, 32'hA3, 4'b0000);
    #1;
    checkOutput("iso_ready_ch3", {31'h0, in_ready}, 32'h1);
    step();
    applyStimulus(1'b0, 2'd1, 32'h0, 4'b0000);
    #1;
    checkOutput("iso_ready_ch1", {31'h0, in_ready}, 32'h0);
    checkOutput("iso_out_valid", {28'h0, out_valid}, 32'hB);
    checkOutput("iso_data0", out_data0, 32'hA0);
    checkOutput("iso_data1", out_data1, 32'h11);
    checkOutput("iso_data3", out_data3, 32'hA3);

    // Fill channel 2 as well, then reset asynchronously between edges
    applyStimulus(1'b1, 2'd2, 32'hC2, 4'b0000);
    step();
    applyStimulus(1'b0, 2'd0, 32'h0, 4'b0000);
    checkOutput("allfull_out_valid", {28'h0, out_valid}, 32'hF);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async_rst_valid", {28'h0, out_valid}, 32'h0);
    checkOutput("async_rst_data1", out_data1, 32'h0);
    checkOutput("async_rst_in_ready", {31'h0, in_ready}, 32'h0);
    step();
    rst = 1'b0;
    applyStimulus(1'b0, 2'd0, 32'h0, 4'b1111);
    step();
    checkOutput("post_rst_valid", {28'h0, out_valid}, 32'h0);
    checkOutput("post_rst_data2", out_data2, 32'h0);

    // Random traffic against a per-channel scoreboard
    for (int c = 0; c < 10000; c++) begin
      logic mReady;
      if (c >= 9990) begin
        applyStimulus(1'b0, 2'($urandom_range(3)), $urandom, 4'b1111);
      end else begin
        applyStimulus(1'($urandom_range(1)), 2'($urandom_range(3)), $urandom,
                      4'($urandom_range(15)));
      end
      #1;
      mReady = (expQ[in_sel].size() == 0) || out_ready[in_sel];
      checkOutput("rnd_in_ready", {31'h0, in_ready}, {31'h0, mReady});
      for (int ch = 0; ch < 4; ch++) begin
        checkOutput($sformatf("rnd_valid_ch%0d", ch), {31'h0, out_valid[ch]},
                    {31'h0, (expQ[ch].size() != 0)});
        if (expQ[ch].size() != 0 && out_ready[ch]) begin
          checkOutput($sformatf("rnd_data_ch%0d", ch), dataOf(ch), expQ[ch][0]);
          void'(expQ[ch].pop_front());
          popCount++;
        end
      end
      if (in_valid && mReady) begin
        expQ[in_sel].push_back(in_data);
        pushCount++;
      end
      step();
    end
    checkOutput("rnd_conservation", 32'(popCount), 32'(pushCount));
    checkOutput("rnd_final_valid", {28'h0, out_valid}, 32'h0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
